// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks a 4-input circuit through all 16 rows and scores its output.
// Define SWEEP_GRAY_ORDER_EN to visit rows in Gray-code order instead of binary order.
module truth_table_sweeper #(
   parameter int          SETTLE_CYCLES = 4,
   parameter logic [15:0] EXPECTED      = 16'h0026
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        dut_out,
   output logic        in1,
   output logic        in2,
   output logic        in3,
   output logic        in4,
   output logic        busy,
   output logic        done,
   output logic [15:0] observed,
   output logic        mismatch,
   output logic [4:0]  mismatch_count
);

   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

   state_t      state_reg;
   logic [3:0]  step_reg;
   logic [3:0]  row_reg;
   logic [7:0]  cnt_reg;
   logic [15:0] table_next;

   function automatic logic [3:0] row_of(input logic [3:0] s);
`ifdef SWEEP_GRAY_ORDER_EN
      return s ^ (s >> 1);
`else
      return s;
`endif
   endfunction

   // The row register is the circuit drive and also the index the sample lands in,
   // so Gray order still fills the table by row.
   assign {in1, in2, in3, in4} = row_reg;

   always_comb begin
      table_next          = observed;
      table_next[row_reg] = dut_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         step_reg       <= '0;
         row_reg        <= '0;
         cnt_reg        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         observed       <= '0;
         mismatch       <= 1'b0;
         mismatch_count <= '0;
      end else if (abort && state_reg != IDLE) begin
         state_reg <= IDLE;
         row_reg   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  observed       <= '0;
                  mismatch       <= 1'b0;
                  mismatch_count <= '0;
                  step_reg       <= '0;
                  busy           <= 1'b1;
                  state_reg      <= APPLY;
               end
            end
            APPLY: begin
               row_reg   <= row_of(step_reg);
               cnt_reg   <= 8'(SETTLE_CYCLES);
               state_reg <= SETTLE;
            end
            SETTLE: begin
               cnt_reg <= cnt_reg - 8'd1;
               if (cnt_reg <= 8'd1) state_reg <= SAMPLE;
            end
            SAMPLE: begin
               observed <= table_next;
               if (dut_out != EXPECTED[row_reg]) mismatch_count <= mismatch_count + 5'd1;
               if (step_reg == 4'd15) begin
                  mismatch  <= |(table_next ^ EXPECTED);
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  step_reg  <= step_reg + 4'd1;
                  state_reg <= APPLY;
               end
            end
            DONE: state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (default settle and settle=1) each driving
// a lagging behavioural circuit model; expected sweep results are queued and scored on done.
module tb_truth_table_sweeper;

   localparam logic [15:0] MODEL_TABLE = 16'h0026;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
   logic dut_out_a, dut_out_b;
   logic in1_a, in2_a, in3_a, in4_a, in1_b, in2_b, in3_b, in4_b;
   logic busy_a, done_a, mismatch_a, busy_b, done_b, mismatch_b;
   logic [15:0] observed_a, observed_b;
   logic [4:0]  mcount_a, mcount_b;
   logic        inv5_a = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] obs;
      logic        mm;
      logic [4:0]  cnt;
      int          len;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   truth_table_sweeper dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .dut_out(dut_out_a),
      .in1(in1_a), .in2(in2_a), .in3(in3_a), .in4(in4_a),
      .busy(busy_a), .done(done_a), .observed(observed_a),
      .mismatch(mismatch_a), .mismatch_count(mcount_a)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .dut_out(dut_out_b),
      .in1(in1_b), .in2(in2_b), .in3(in3_b), .in4(in4_b),
      .busy(busy_b), .done(done_b), .observed(observed_b),
      .mismatch(mismatch_b), .mismatch_count(mcount_b)
   );

   // Circuit models: output follows the applied row with a 3-register lag.
   logic [3:0] pa1 = '0, pa2 = '0, pa3 = '0, pb1 = '0, pb2 = '0, pb3 = '0;
   always @(posedge clk) begin
      pa1 <= {in1_a, in2_a, in3_a, in4_a}; pa2 <= pa1; pa3 <= pa2;
      pb1 <= {in1_b, in2_b, in3_b, in4_b}; pb2 <= pb1; pb3 <= pb2;
   end
   assign dut_out_a = MODEL_TABLE[pa3] ^ (inv5_a && pa3 == 4'd5);
   assign dut_out_b = MODEL_TABLE[pb3];

   // Row log for instance A: distinct rows seen while busy (skipping the APPLY cycle of row 0).
   logic [3:0] seen_q[$];
   logic       prev_busy_a = 1'b0;
   always @(negedge clk) begin
      if (busy_a && prev_busy_a) begin
         if (seen_q.size() == 0 || seen_q[$] != {in1_a, in2_a, in3_a, in4_a})
            seen_q.push_back({in1_a, in2_a, in3_a, in4_a});
      end
      prev_busy_a <= busy_a;
   end

   function automatic logic [3:0] row_of(input int s);
      logic [3:0] v;
      v = 4'(s);
`ifdef SWEEP_GRAY_ORDER_EN
      return v ^ (v >> 1);
`else
      return v;
`endif
   endfunction

   function automatic logic [4:0] popcount(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
      return c;
   endfunction

   // Start a sweep on one instance, wait for done, pop the expected result and score it.
   task automatic sweep_and_score(input bit sel, input string name);
      exp_t e;
      int   edge_n;
      @(negedge clk);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      n_checks++;
      if ((sel ? busy_b : busy_a) !== 1'b1) begin
         n_fail++; $display("FAIL %s busy_after_start: got %b want 1", name, sel ? busy_b : busy_a);
      end
      edge_n = -1;
      for (int k = 1; k <= 300 && edge_n < 0; k++) begin
         @(posedge clk); #1;
         if ((sel ? done_b : done_a) === 1'b1) edge_n = k;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (edge_n != e.len) begin
         n_fail++; $display("FAIL %s done_edge: got %0d want %0d", name, edge_n, e.len);
      end
      n_checks++;
      if ((sel ? observed_b : observed_a) !== e.obs) begin
         n_fail++; $display("FAIL %s observed: got %h want %h", name, sel ? observed_b : observed_a, e.obs);
      end
      n_checks++;
      if ((sel ? mismatch_b : mismatch_a) !== e.mm) begin
         n_fail++; $display("FAIL %s mismatch: got %b want %b", name, sel ? mismatch_b : mismatch_a, e.mm);
      end
      n_checks++;
      if ((sel ? mcount_b : mcount_a) !== e.cnt) begin
         n_fail++; $display("FAIL %s mismatch_count: got %0d want %0d", name, sel ? mcount_b : mcount_a, e.cnt);
      end
      @(posedge clk); #1;
      n_checks++;
      if ((sel ? done_b : done_a) !== 1'b0 || (sel ? busy_b : busy_a) !== 1'b0) begin
         n_fail++; $display("FAIL %s done_pulse_width: done=%b busy=%b want 0 0", name,
                            sel ? done_b : done_a, sel ? busy_b : busy_a);
      end
      $display("sweep %s: done at edge %0d observed=%h mismatch=%b count=%0d", name, edge_n,
               sel ? observed_b : observed_a, sel ? mismatch_b : mismatch_a, sel ? mcount_b : mcount_a);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if ({busy_a, done_a, mismatch_a, in1_a, in2_a, in3_a, in4_a, observed_a, mcount_a} !== '0) begin
         n_fail++; $display("FAIL reset_a: got busy=%b done=%b mm=%b in=%b%b%b%b obs=%h cnt=%0d want all 0",
                            busy_a, done_a, mismatch_a, in1_a, in2_a, in3_a, in4_a, observed_a, mcount_a);
      end
      n_checks++;
      if ({busy_b, done_b, mismatch_b, in1_b, in2_b, in3_b, in4_b, observed_b, mcount_b} !== '0) begin
         n_fail++; $display("FAIL reset_b: got busy=%b done=%b obs=%h cnt=%0d want all 0",
                            busy_b, done_b, observed_b, mcount_b);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_clean_sweep();
      logic [3:0] want_rows[$];
      exp_q.push_back('{obs: MODEL_TABLE, mm: 1'b0, cnt: 5'd0, len: 96});
      for (int s = 0; s < 16; s++) want_rows.push_back(row_of(s));
      seen_q.delete();
      sweep_and_score(1'b0, "clean");
      n_checks++;
      if (seen_q.size() != 16) begin
         n_fail++; $display("FAIL row_order_len: got %0d rows want 16", seen_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (seen_q[i] !== want_rows[i]) begin
               n_fail++; $display("FAIL row_order[%0d]: got %0d want %0d", i, seen_q[i], want_rows[i]);
            end
`ifdef SWEEP_GRAY_ORDER_EN
            if (i > 0) begin
               n_checks++;
               if ($countones(seen_q[i] ^ seen_q[i-1]) != 1) begin
                  n_fail++; $display("FAIL gray_one_toggle[%0d]: got %b -> %b want one bit change",
                                     i, seen_q[i-1], seen_q[i]);
               end
            end
`endif
         end
      end
   endtask

   task automatic test_fault_row5();
      inv5_a = 1'b1;
      exp_q.push_back('{obs: 16'h0006, mm: 1'b1, cnt: 5'd1, len: 96});
      sweep_and_score(1'b0, "fault_row5");
      inv5_a = 1'b0;
   endtask

   task automatic test_short_settle();
      logic [15:0] obs;
      // With one settle cycle, each sample still sees the circuit's response to the previous row.
      obs = '0;
      obs[row_of(0)] = MODEL_TABLE[0];
      for (int s = 1; s < 16; s++) obs[row_of(s)] = MODEL_TABLE[row_of(s - 1)];
      exp_q.push_back('{obs: obs, mm: |(obs ^ MODEL_TABLE), cnt: popcount(obs ^ MODEL_TABLE), len: 48});
      sweep_and_score(1'b1, "short_settle");
      n_checks++;
      if (mismatch_b !== 1'b1) begin
         n_fail++; $display("FAIL short_settle_stale: got mismatch=%b want 1", mismatch_b);
      end
   endtask

   task automatic test_abort();
      logic [15:0] part;
      bit          saw_done;
      part = '0;
      for (int s = 0; s < 7; s++) part[row_of(s)] = MODEL_TABLE[row_of(s)];
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      repeat (43) @(posedge clk);
      @(negedge clk);
      abort_a = 1'b1;
      @(posedge clk); #1;
      abort_a = 1'b0;
      n_checks++;
      if (busy_a !== 1'b0 || {in1_a, in2_a, in3_a, in4_a} !== 4'b0) begin
         n_fail++; $display("FAIL abort_idle: got busy=%b in=%b%b%b%b want 0 0000",
                            busy_a, in1_a, in2_a, in3_a, in4_a);
      end
      n_checks++;
      if (observed_a !== part || mcount_a !== 5'd0) begin
         n_fail++; $display("FAIL abort_partial: got obs=%h cnt=%0d want %h 0", observed_a, mcount_a, part);
      end
      saw_done = 1'b0;
      for (int k = 0; k < 120; k++) begin
         @(posedge clk); #1;
         if (done_a === 1'b1 || busy_a === 1'b1) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done) begin
         n_fail++; $display("FAIL abort_no_done: got done/busy activity want none");
      end
      $display("abort: idle after step 7, observed=%h", observed_a);
      exp_q.push_back('{obs: MODEL_TABLE, mm: 1'b0, cnt: 5'd0, len: 96});
      sweep_and_score(1'b0, "after_abort");
   endtask

   task automatic test_reset_mid_sweep();
      int edge_n;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({busy_a, done_a, mismatch_a, in1_a, in2_a, in3_a, in4_a, observed_a, mcount_a} !== '0) begin
         n_fail++; $display("FAIL reset_mid_sweep: got busy=%b in=%b%b%b%b obs=%h cnt=%0d want all 0",
                            busy_a, in1_a, in2_a, in3_a, in4_a, observed_a, mcount_a);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      $display("reset mid-sweep: outputs cleared");
      // Extra start pulses while busy must not restart or stretch the sweep.
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      edge_n = -1;
      for (int k = 1; k <= 300 && edge_n < 0; k++) begin
         start_a = (k == 20 || k == 50);
         @(posedge clk); #1;
         if (done_a === 1'b1) edge_n = k;
      end
      start_a = 1'b0;
      n_checks++;
      if (edge_n != 96) begin
         n_fail++; $display("FAIL start_ignored_len: got done edge %0d want 96", edge_n);
      end
      n_checks++;
      if (observed_a !== MODEL_TABLE) begin
         n_fail++; $display("FAIL start_ignored_obs: got %h want %h", observed_a, MODEL_TABLE);
      end
      $display("start while busy: done at edge %0d", edge_n);
   endtask

   initial begin
      test_reset();
      test_clean_sweep();
      test_fault_row5();
      test_short_settle();
      test_abort();
      test_reset_mid_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential test harness that drives the four inputs of a 4-input Cello-style combinational logic circuit and captures its single output. On `start` it steps through all 16 input rows, holds each row for a programmable settle interval, samples the circuit output, and builds the observed 16-bit truth table. It then compares that table against the expected hex function. The block sits directly around the circuit under test: upstream as its input driver, downstream as its output consumer.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each row is held before sampling; legal range 1..255.
- `EXPECTED`, default 16'h0026: expected truth table; bit r is the expected output for row r.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a sweep when sampled high in IDLE.
- `abort` in 1: cancels a sweep in progress.
- `dut_out` in 1: output of the circuit under test.
- `in1`, `in2`, `in3`, `in4` out 1 each: drive the circuit inputs. For row r: `in1`=r[3], `in2`=r[2], `in3`=r[1], `in4`=r[0].
- `busy` out 1: high from APPLY of row 0 through SAMPLE of the final row.
- `done` out 1: one-cycle pulse when the sweep completes.
- `observed` out 16: captured truth table; bit r = `dut_out` sampled for row r.
- `mismatch` out 1: equals |(`observed` ^ `EXPECTED`); valid from the `done` pulse onward.
- `mismatch_count` out 5: number of set bits in `observed` ^ `EXPECTED`, range 0..16.

## Operation
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE, `start`=1: clear `observed`, `mismatch` and `mismatch_count`; set the step index to 0; go to APPLY. `start` is ignored in every other state.
- APPLY: drive the row for the current step onto in1..in4; load the settle counter with SETTLE_CYCLES; go to SETTLE.
- SETTLE: decrement the counter. When it reaches 0, go to SAMPLE. in1..in4 are held stable.
- SAMPLE: write `dut_out` into `observed`[row]. If it differs from `EXPECTED`[row], increment `mismatch_count`. If the step is 15, go to DONE; otherwise increment the step and go to APPLY.
- DONE: pulse `done` for one cycle; drive `mismatch` from the final table; return to IDLE.
- `observed`, `mismatch` and `mismatch_count` hold their values in IDLE until the next accepted `start`.
- `abort` has priority over every transition except `rst`. Any non-IDLE state goes to IDLE on the next edge. `done` is not pulsed. Partial `observed` and `mismatch_count` values are retained. in1..in4 return to 0.
- `abort` and `start` asserted together in IDLE: `start` is accepted.
- `rst` has priority over everything, including mid-sweep. All outputs become 0 and the state becomes IDLE.
- Step-to-row mapping: row = step in binary order, or the Gray-code mapping described under Configuration.

## Timing
- Each row takes SETTLE_CYCLES+2 cycles: APPLY 1, SETTLE SETTLE_CYCLES, SAMPLE 1.
- A full sweep is 16·(SETTLE_CYCLES+2) cycles in the busy states, plus 1 DONE cycle.
- `busy` rises on the edge after `start` is accepted. `done` is high in the cycle after the last SAMPLE.
- With default parameters, `start` is accepted at edge 0 and `done` is high for cycle 97.
- `dut_out` is sampled exactly SETTLE_CYCLES+1 edges after in1..in4 change.
- in1..in4 are registered outputs and change only on APPLY edges.

## Configuration
- `SWEEP_GRAY_ORDER_EN` defined: step s maps to row s ^ (s>>1). Successive rows differ in exactly one input, including the wrap 8→0, which limits glitching in slow gate chains.
- Not defined: row = s (binary order 0..15).
- In both modes, `observed` is indexed by row, not by step. The final table is therefore identical for a glitch-free circuit.

## Test plan
- Behavioural circuit model returns `EXPECTED`[row] with a 3-cycle lag, default parameters, `start` pulsed → `done` at cycle 97, `observed`=16'h0026, `mismatch`=0, `mismatch_count`=0.
- Model with row 5 output inverted → `observed`=16'h0006, `mismatch`=1, `mismatch_count`=1.
- SETTLE_CYCLES=1 with a model lag of 3 → stale samples produce `mismatch`=1. Sweep length is 48 cycles to `done`.
- `abort` asserted during SETTLE of step 7 → IDLE next edge, `busy`=0, no `done` pulse, `observed` bits 8..15 still 0. A following `start` completes a clean sweep.
- `rst` pulsed mid-sweep → all outputs 0 on the next edge. `start` pulsed while `busy` → ignored, sweep length unchanged.
- With `SWEEP_GRAY_ORDER_EN` defined → rows applied in order 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, with exactly one input toggling per APPLY. Final `observed`=16'h0026.
